mips32_fetch_queue: RTL and testbench

- Instruction prefetch buffer sitting directly upstream of the IF/ID pipeline register.
- Issues word-addressed fetch requests to instruction memory and buffers the in-order responses in a FIFO, each tagged with its NPC (pc+1).
- Presents instructions to IF with a valid/ready handshake.
- On a taken branch, a redirect flushes the buffer, discards in-flight responses and restarts fetch at the target.

---
 rtl/mips32_fetch_queue.sv | 163 ++++++++++++++++
 tb/tb_mips32_fetch_queue.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch queue in front of the IF/ID register: issues word fetches and buffers in-order replies tagged with NPC.
// Optional macro MIPS32_FQ_BYPASS_EN forwards a reply straight to the output when the queue is empty.

module mips32_fetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk1,
  input logic             rst_n,
  input logic             push_i,
  input logic             pop_i,
  input logic [CNT_W-1:0] count_i
);
  // A push into a full queue without a matching pop means the issue reservation was broken.
  a_no_overflow: assert property (@(posedge clk1) disable iff (!rst_n)
    !(push_i && !pop_i && (count_i == CNT_W'(DEPTH))));
endmodule

module mips32_fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 10,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_npc,
  input  logic              instr_ready
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] npc_mem_q   [DEPTH];

  logic [OCC_W-1:0]  occupancy_s;
  logic [ADDR_W-1:0] resp_npc_s;
  logic              issue_s;
  logic              grant_s;
  logic              accept_s;
  logic              head_valid_s;
  logic              bypass_s;
  logic              push_s;
  logic              pop_s;

  // Slots already promised: buffered entries plus replies that will actually be kept.
  assign occupancy_s  = OCC_W'(count_q) + OCC_W'(outstanding_q - drop_cnt_q);
  assign issue_s      = rst_n && !halt && !redirect_valid &&
                        (outstanding_q < OUT_W'(MAX_OUT)) && (occupancy_s < OCC_W'(DEPTH));
  assign grant_s      = issue_s && mem_gnt;
  assign accept_s     = mem_rvalid && (drop_cnt_q == '0) && !redirect_valid;
  assign head_valid_s = (count_q != '0);
  assign resp_npc_s   = resp_pc_q + ADDR_W'(1);

`ifdef MIPS32_FQ_BYPASS_EN
  assign bypass_s = accept_s && !head_valid_s;
`else
  assign bypass_s = 1'b0;
`endif

  assign pop_s  = head_valid_s && instr_ready && !redirect_valid;
  assign push_s = accept_s && !(bypass_s && instr_ready);

  assign mem_req     = issue_s;
  assign mem_addr    = fetch_pc_q;
  assign instr_valid = head_valid_s || bypass_s;
  assign instr       = bypass_s ? mem_rdata  : instr_mem_q[rd_ptr_q];
  assign instr_npc   = bypass_s ? resp_npc_s : npc_mem_q[rd_ptr_q];

  // Next-state for fetch/response pointers, in-flight accounting and queue occupancy.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (redirect_valid) begin
      // Every reply still owed after this cycle belongs to the old path.
      fetch_pc_d    = redirect_pc;
      resp_pc_d     = redirect_pc;
      outstanding_d = outstanding_q - OUT_W'(mem_rvalid);
      drop_cnt_d    = outstanding_q - OUT_W'(mem_rvalid);
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
    end else begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(grant_s);
      resp_pc_d     = accept_s ? resp_npc_s : resp_pc_q;
      outstanding_d = outstanding_q + OUT_W'(grant_s) - OUT_W'(mem_rvalid);
      drop_cnt_d    = (mem_rvalid && (drop_cnt_q != '0)) ? drop_cnt_q - OUT_W'(1) : drop_cnt_q;
      count_d       = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      wr_ptr_d      = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d      = rd_ptr_q + PTR_W'(pop_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // Queue storage; entries clear on reset so the head reads zero.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= 32'd0;
        npc_mem_q[i]   <= '0;
      end
    end else if (push_s) begin
      instr_mem_q[wr_ptr_q] <= mem_rdata;
      npc_mem_q[wr_ptr_q]   <= resp_npc_s;
    end
  end

  mips32_fetch_queue_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .count_i (count_q)
  );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Scoreboard bench for mips32_fetch_queue: in-order memory responder, program-flow reference stream, directed and random phases.
`timescale 1ns/1ps
module tb_mips32_fetch_queue;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 10;
  localparam int MAX_OUT = 2;
`ifdef MIPS32_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              halt = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt = 1'b0;
  logic              mem_rvalid = 1'b0;
  logic [31:0]       mem_rdata = 32'd0;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_npc;
  logic              instr_ready = 1'b0;

  mips32_fetch_queue dut (
    .clk1           (clk1),
    .rst_n          (rst_n),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_npc      (instr_npc),
    .instr_ready    (instr_ready)
  );

  always #5 clk1 = ~clk1;

  typedef struct { logic [ADDR_W-1:0] addr; int rdy; } pend_t;
  typedef struct { logic [31:0] ins; logic [ADDR_W-1:0] npc; } exp_t;

  pend_t pend[$];
  exp_t  exp_q[$];
  int    stale = 0;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_pops = 0;
  int    max_delay = 0;
  bit    rv_rand = 1'b0;
  bit    wrap_seen = 1'b0;
  logic [ADDR_W-1:0] fetch_m = '0;
  logic [ADDR_W-1:0] prog_m = '0;

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hA0 + {22'd0, a} + ({22'd0, a} << 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: requests in flight, replies owed to a dead path, and the expected instruction stream.
  always @(negedge clk1) begin
    if (!rst_n) begin
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_instr_npc", 32'(instr_npc), 32'd0);
      pend.delete();
      exp_q.delete();
      stale   = 0;
      fetch_m = '0;
      prog_m  = '0;
    end else begin
      int out_n;
      bit exp_req;
      bit exp_valid;
      out_n     = pend.size();
      exp_req   = !halt && !redirect_valid && (out_n < MAX_OUT) &&
                  ((exp_q.size() + out_n - stale) < DEPTH);
      exp_valid = (exp_q.size() > 0) || (BYP && (stale == 0) && !redirect_valid && mem_rvalid);
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
      if (redirect_valid) begin
        exp_q.delete();
        if (mem_rvalid && pend.size() > 0) void'(pend.pop_front());
        stale   = pend.size();
        fetch_m = redirect_pc;
        prog_m  = redirect_pc;
      end else begin
        if (mem_rvalid && pend.size() > 0) begin
          void'(pend.pop_front());
          if (stale > 0) stale--;
          else begin
            exp_q.push_back('{mem_word(prog_m), prog_m + 10'd1});
            prog_m = prog_m + 10'd1;
          end
        end
        if (mem_req && mem_gnt) begin
          chk("mem_addr", 32'(mem_addr), 32'(fetch_m));
          pend.push_back('{fetch_m, cyc + 1 + (rv_rand ? int'($urandom_range(0, max_delay)) : max_delay)});
          fetch_m = fetch_m + 10'd1;
        end
      end
    end
  end

  // Monitor: every presented instruction must match the head of the expected stream.
  always @(negedge clk1) begin
    #1;
    if (rst_n && instr_valid && !redirect_valid) begin
      chk("exp_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("instr", instr, exp_q[0].ins);
        chk("instr_npc", 32'(instr_npc), 32'(exp_q[0].npc));
        if (instr_npc == 10'd0 && instr == mem_word(10'h3FF)) wrap_seen = 1'b1;
        if (instr_ready) begin
          void'(exp_q.pop_front());
          n_pops++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    cyc++;
    #1;
    if (rst_n && pend.size() > 0 && pend[0].rdy <= cyc && (!rv_rand || $urandom_range(0, 3) != 0)) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
  endtask

  task automatic at_neg();
    @(negedge clk1);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [ADDR_W-1:0] resume_pc;
    mem_gnt = 1'b1;
    rst_n   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Fill under backpressure: exactly DEPTH words held, requests stop.
    repeat (10) tick();
    at_neg();
    chk("bp_mem_req", 32'(mem_req), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_instr", instr, 32'h000000A0);
    chk("bp_npc", 32'(instr_npc), 32'd1);
    tick();
    instr_ready = 1'b1;
    repeat (20) tick();

    // Redirect with 2 buffered and 2 outstanding.
    redirect_valid = 1'b1;
    redirect_pc    = 10'h100;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    max_delay      = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (pend.size() == 2 && exp_q.size() == 2) found = 1'b1;
    end
    chk("rd_setup", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 10'h020;
    tick();
    redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      at_neg();
      if (instr_valid) found = 1'b1;
      else tick();
    end
    chk("rd_valid_seen", 32'(found), 32'd1);
    chk("rd_instr", instr, mem_word(10'h020));
    chk("rd_npc", 32'(instr_npc), 32'h21);

    // Redirect in a cycle that also has a reply and a pop.
    tick();
    instr_ready = 1'b1;
    max_delay   = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (mem_rvalid && exp_q.size() > 0) found = 1'b1;
    end
    chk("rdp_setup", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 10'h040;
    tick();
    redirect_valid = 1'b0;
    at_neg();
    chk("rdp_valid", 32'(instr_valid), 32'd0);

    // Halt with one request outstanding.
    max_delay = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (pend.size() == 1) found = 1'b1;
    end
    chk("halt_setup", 32'(found), 32'd1);
    halt      = 1'b1;
    resume_pc = fetch_m;
    repeat (8) tick();
    at_neg();
    chk("halt_no_req", 32'(mem_req), 32'd0);
    chk("halt_drained", 32'(instr_valid), 32'd0);
    tick();
    halt = 1'b0;
    at_neg();
    chk("resume_req", 32'(mem_req), 32'd1);
    chk("resume_addr", 32'(mem_addr), 32'(resume_pc));

    // Address wrap at the top of memory.
    tick();
    max_delay      = 0;
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FD;
    tick();
    redirect_valid = 1'b0;
    repeat (15) tick();
    at_neg();
    chk("wrap_seen", 32'(wrap_seen), 32'd1);

    // Random traffic with one mid-stream reset.
    rv_rand   = 1'b1;
    max_delay = 3;
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n          = (i != 1500);
      mem_gnt        = ($urandom_range(0, 9) < 7);
      instr_ready    = ($urandom_range(0, 3) != 0);
      halt           = ($urandom_range(0, 19) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = ($urandom_range(0, 1) == 0) ? 10'h3FE : 10'($urandom);
    end
    tick();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    at_neg();
    chk("progress", 32'(n_pops > 500), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
